// File: rtl/register_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_ctrl_pkg
//
// Shared definitions for the register-port arbiter and its sub-modules:
//   - controller state encoding (ARB / CLEAR)
//   - default register-file geometry (count, width, address width)
//   - requester ID width and a small ID -> one-hot helper
// -----------------------------------------------------------------------------
package reg_ctrl_pkg;

    localparam int REG_COUNT_DEF = 16;
    localparam int REG_SIZE_DEF  = 8;
    localparam int ADDR_W_DEF    = 4;

    // Two requesters, so a single bit identifies one of them.
    localparam int REQ_ID_W      = 1;
    localparam int NUM_REQ       = 2;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } ctrl_state_t;

    // Expand a requester ID into the per-requester one-hot vector used on
    // the response valid outputs.
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [REQ_ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/register_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//
// Two-input round-robin arbiter with a registered priority pointer.
// Grants are combinational. When both inputs request, the pointer holder
// wins and the pointer then moves to the loser. A single request is granted
// directly and leaves the pointer alone. No grant is issued while i_en is
// low or reset is asserted, and the pointer only moves on an enabled,
// contended cycle.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (pointer -> 0)
//   i_en     in   arbitration enable for this cycle
//   i_req    in   [1:0] request vector
//   o_gnt    out  [1:0] one-hot (or zero) grant vector
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_prio;
    logic w_contend;

    assign w_contend = i_req[0] & i_req[1];

    always_comb begin
        o_gnt = 2'b00;
        if (reset_n && i_en) begin
            if (w_contend) begin
                o_gnt = r_prio ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Winner is the current holder, so handing priority to the loser is
    // simply a toggle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= 1'b0;
        end else if (i_en && w_contend) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/register_port_arbiter.sv
// -----------------------------------------------------------------------------
// register_port_arbiter
//
// Shares one register unit (one read port, one write port per cycle)
// between two requesters. Each port is arbitrated independently by its own
// round-robin arbiter, so a read from one requester and a write from the
// other proceed in the same cycle. A clear sequencer walks every address
// and stores zero without touching the register unit's own reset.
//
// Ports:
//   clock, reset_n           clock and asynchronous active-low reset
//   req_valid[1:0]           per-requester request valid
//   req_write[1:0]           per-requester op (1 = write, 0 = read)
//   req_addr[1:0]            per-requester register address
//   req_wdata[1:0]           per-requester write data
//   req_ready[1:0]           combinational grant for this cycle
//   rsp_valid[1:0]           one-cycle read response pulse per requester
//   rsp_data                 shared read data (register unit output)
//   clr_start                request to zero all registers
//   clr_busy                 clear sequence in progress
//   ru_load / ru_load_addr   register unit read enable / address
//   ru_store / ru_store_addr register unit write enable / address
//   ru_data_in               register unit write data
//   ru_data_out              register unit registered read data
// -----------------------------------------------------------------------------
module register_port_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEF,
    parameter int REG_SIZE  = REG_SIZE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,

    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [1:0][ADDR_W-1:0]    req_addr,
    input  logic [1:0][REG_SIZE-1:0]  req_wdata,
    output logic [1:0]                req_ready,

    output logic [1:0]                rsp_valid,
    output logic [REG_SIZE-1:0]       rsp_data,

    input  logic                      clr_start,
    output logic                      clr_busy,

    output logic                      ru_load,
    output logic                      ru_store,
    output logic [ADDR_W-1:0]         ru_load_addr,
    output logic [ADDR_W-1:0]         ru_store_addr,
    output logic [REG_SIZE-1:0]       ru_data_in,
    input  logic [REG_SIZE-1:0]       ru_data_out
);

    ctrl_state_t           r_state;
    ctrl_state_t           w_state_nxt;
    logic [ADDR_W-1:0]     r_clr_cnt;
    logic                  r_rsp_pend;
    logic [REQ_ID_W-1:0]   r_rsp_id;

    logic                  w_arb_en;
    logic                  w_clr_last;
    logic [1:0]            w_rd_req;
    logic [1:0]            w_wr_req;
    logic [1:0]            w_rd_gnt;
    logic [1:0]            w_wr_gnt;

    // A clr_start in ARB suppresses all grants that cycle; CLEAR owns the
    // write port outright, so neither port arbitrates there.
    assign w_arb_en   = (r_state == ST_ARB) && !clr_start;
    assign w_clr_last = (r_clr_cnt == ADDR_W'(REG_COUNT - 1));

    // Each requester's op selects exactly one port.
    assign w_rd_req = req_valid & ~req_write;
    assign w_wr_req = req_valid &  req_write;

    rr_arb2 u_rd_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_arb_en),
        .i_req   (w_rd_req),
        .o_gnt   (w_rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_arb_en),
        .i_req   (w_wr_req),
        .o_gnt   (w_wr_gnt)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_ARB: begin
                if (clr_start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Leave on the terminal count rather than on the wrap so the
                // sequence lasts exactly REG_COUNT cycles.
                if (w_clr_last) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs and register-unit muxing
    // Everything here is forced low while reset is asserted.
    // ---------------------------------------------------------------------
    always_comb begin
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;
        rsp_data      = '0;
        clr_busy      = 1'b0;
        ru_load       = 1'b0;
        ru_load_addr  = '0;
        ru_store      = 1'b0;
        ru_store_addr = '0;
        ru_data_in    = '0;

        if (reset_n) begin
            req_ready = w_rd_gnt | w_wr_gnt;

            // Response path is independent of state so a read accepted in
            // the last ARB cycle still completes during CLEAR.
            if (r_rsp_pend) begin
                rsp_valid = id_to_onehot(r_rsp_id);
            end
            rsp_data = ru_data_out;

            if (w_rd_gnt[1]) begin
                ru_load      = 1'b1;
                ru_load_addr = req_addr[1];
            end else if (w_rd_gnt[0]) begin
                ru_load      = 1'b1;
                ru_load_addr = req_addr[0];
            end

            if (r_state == ST_CLEAR) begin
                clr_busy      = 1'b1;
                ru_store      = 1'b1;
                ru_store_addr = r_clr_cnt;
                ru_data_in    = '0;
            end else if (w_wr_gnt[1]) begin
                ru_store      = 1'b1;
                ru_store_addr = req_addr[1];
                ru_data_in    = req_wdata[1];
            end else if (w_wr_gnt[0]) begin
                ru_store      = 1'b1;
                ru_store_addr = req_addr[0];
                ru_data_in    = req_wdata[0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Clear address counter: held at zero in ARB, so CLEAR always starts
    // from address 0; wraps back to zero on the final CLEAR cycle.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end else begin
            r_clr_cnt <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Read response tracking: the register unit returns data one cycle after
    // the load, so remember whether a load was issued and for whom.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_pend <= 1'b0;
            r_rsp_id   <= '0;
        end else begin
            r_rsp_pend <= |w_rd_gnt;
            r_rsp_id   <= w_rd_gnt[1];
        end
    end

endmodule

// File: tb/tb_register_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_register_port_arbiter
//
// Bench for register_port_arbiter. A simple register unit (registered read,
// read-before-write) sits on the ru_* side. A behavioural model tracks the
// register contents, the two priority pointers, the outstanding response and
// the clear progress, and every cycle's outputs are compared against it.
// Directed sequences are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_register_port_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int NREG = 16;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_write;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][DW-1:0]   req_wdata;
    logic [1:0]           req_ready;
    logic [1:0]           rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 ru_load;
    logic                 ru_store;
    logic [AW-1:0]        ru_load_addr;
    logic [AW-1:0]        ru_store_addr;
    logic [DW-1:0]        ru_data_in;
    logic [DW-1:0]        ru_data_out;

    register_port_arbiter #(
        .REG_COUNT (NREG),
        .REG_SIZE  (DW),
        .ADDR_W    (AW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .ru_load       (ru_load),
        .ru_store      (ru_store),
        .ru_load_addr  (ru_load_addr),
        .ru_store_addr (ru_store_addr),
        .ru_data_in    (ru_data_in),
        .ru_data_out   (ru_data_out)
    );

    always #5 clock = ~clock;

    // Register unit: registered read of the pre-write contents.
    logic [DW-1:0] hu_mem [NREG];
    always @(posedge clock) begin
        if (ru_load)  ru_data_out <= hu_mem[ru_load_addr];
        if (ru_store) hu_mem[ru_store_addr] <= ru_data_in;
    end

    // Counters and model state
    int n_vec = 0;
    int n_err = 0;

    int m_rd_prio, m_wr_prio;
    int m_pend_id;           // -1: no response due this cycle
    int m_pend_data;         // -1: contents not yet known
    int m_clr_left;          // 0: arbitrating; >0: clear cycles remaining
    int m_clr_idx;
    int ref_mem [NREG];

    // Samples of the last step, for directed literal checks
    logic [1:0]    s_ready, s_rsp_valid;
    logic [DW-1:0] s_rsp_data;
    logic          s_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd_prio  = 0;
        m_wr_prio  = 0;
        m_pend_id  = -1;
        m_pend_data = -1;
        m_clr_left = 0;
        m_clr_idx  = 0;
    endtask

    // One clock cycle. Called at posedge+1 with inputs already driven;
    // compares mid-cycle, then advances the model across the next edge.
    task automatic step();
        int  rw, ww;
        bit  arb, r0, r1, w0, w1;
        logic [1:0] er;
        rw = -1;
        ww = -1;
        #3;
        arb = (m_clr_left == 0) && !clr_start;
        r0 = arb && req_valid[0] && !req_write[0];
        r1 = arb && req_valid[1] && !req_write[1];
        w0 = arb && req_valid[0] &&  req_write[0];
        w1 = arb && req_valid[1] &&  req_write[1];
        if (r0 && r1) rw = m_rd_prio; else if (r0) rw = 0; else if (r1) rw = 1;
        if (w0 && w1) ww = m_wr_prio; else if (w0) ww = 0; else if (w1) ww = 1;
        er = 2'b00;
        if (rw >= 0) er[rw] = 1'b1;
        if (ww >= 0) er[ww] = 1'b1;

        chk("req_ready", 32'(req_ready), 32'(er));
        chk("clr_busy",  32'(clr_busy),  32'(m_clr_left != 0));
        chk("rsp_valid", 32'(rsp_valid), (m_pend_id < 0) ? 32'd0 : (32'd1 << m_pend_id));
        if (m_pend_id >= 0 && m_pend_data >= 0)
            chk("rsp_data", 32'(rsp_data), 32'(m_pend_data));
        chk("ru_load", 32'(ru_load), 32'(rw >= 0));
        if (rw >= 0) chk("ru_load_addr", 32'(ru_load_addr), 32'(req_addr[rw]));
        if (m_clr_left != 0) begin
            chk("ru_store", 32'(ru_store), 32'd1);
            chk("ru_store_addr", 32'(ru_store_addr), 32'(m_clr_idx));
            chk("ru_data_in", 32'(ru_data_in), 32'd0);
        end else if (ww >= 0) begin
            chk("ru_store", 32'(ru_store), 32'd1);
            chk("ru_store_addr", 32'(ru_store_addr), 32'(req_addr[ww]));
            chk("ru_data_in", 32'(ru_data_in), 32'(req_wdata[ww]));
        end else begin
            chk("ru_store", 32'(ru_store), 32'd0);
        end

        s_ready     = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        s_busy      = clr_busy;

        @(posedge clock);
        if (r0 && r1) m_rd_prio = 1 - rw;
        if (w0 && w1) m_wr_prio = 1 - ww;
        if (rw >= 0) begin
            m_pend_id   = rw;
            m_pend_data = ref_mem[req_addr[rw]];
        end else begin
            m_pend_id = -1;
        end
        if (m_clr_left != 0) begin
            ref_mem[m_clr_idx] = 0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            if (ww >= 0) ref_mem[req_addr[ww]] = int'(req_wdata[ww]);
            if (clr_start) begin
                m_clr_left = NREG;
                m_clr_idx  = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_write = 2'b00;
        clr_start = 1'b0;
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int a, input int d);
        req_valid[i] = v;
        req_write[i] = w;
        req_addr[i]  = AW'(a);
        req_wdata[i] = DW'(d);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   32'(req_ready), 32'd0);
        chk({tag, "_rspv"},    32'(rsp_valid), 32'd0);
        chk({tag, "_busy"},    32'(clr_busy),  32'd0);
        chk({tag, "_load"},    32'(ru_load),   32'd0);
        chk({tag, "_store"},   32'(ru_store),  32'd0);
        chk({tag, "_laddr"},   32'(ru_load_addr),  32'd0);
        chk({tag, "_saddr"},   32'(ru_store_addr), 32'd0);
        chk({tag, "_din"},     32'(ru_data_in),    32'd0);
    endtask

    initial begin
        int busy_cnt, rdy_cnt;
        logic [1:0] gseq [5];
        logic [1:0] vseq [5];
        logic [DW-1:0] dseq [5];

        reset_n   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        idle();
        for (int i = 0; i < NREG; i++) ref_mem[i] = -1;
        model_reset();

        // Reset state
        #2;
        chk_all_zero("reset");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Initial clear so the register contents are known
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (NREG) step();
        step();
        chk("clr_done_busy", 32'(s_busy), 32'd0);

        // Req0 writes 0x5A to addr 3, then reads it back
        set_req(0, 1, 1, 3, 8'h5A);
        step();
        chk("t1_wr_ready", 32'(s_ready), 32'd1);
        set_req(0, 1, 0, 3, 0);
        step();
        idle();
        step();
        chk("t1_rsp_valid", 32'(s_rsp_valid), 32'd1);
        chk("t1_rsp_data",  32'(s_rsp_data),  32'h5A);

        // Seed addrs 1, 2, then both requesters read every cycle
        set_req(1, 1, 1, 1, 8'h11);
        step();
        set_req(1, 1, 1, 2, 8'h22);
        step();
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle();
            step();
            gseq[k] = s_ready;
            vseq[k] = s_rsp_valid;
            dseq[k] = s_rsp_data;
        end
        for (int k = 0; k < 4; k++) begin
            chk("t2_grant", 32'(gseq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_rspv",  32'(vseq[k+1]), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_rspd",  32'(dseq[k+1]), (k % 2 == 0) ? 32'h11 : 32'h22);
        end

        // Same-cycle read and write to addr 7: read sees the old value
        set_req(0, 1, 1, 7, 8'h77);
        step();
        set_req(0, 1, 0, 7, 0);
        set_req(1, 1, 1, 7, 8'h33);
        step();
        chk("t3_both_ready", 32'(s_ready), 32'd3);
        idle();
        step();
        chk("t3_old_data", 32'(s_rsp_data), 32'h77);
        set_req(0, 1, 0, 7, 0);
        step();
        idle();
        step();
        chk("t3_new_data", 32'(s_rsp_data), 32'h33);

        // clr_start with a read pending from the prior cycle
        set_req(0, 1, 0, 3, 0);
        step();
        idle();
        clr_start = 1'b1;
        step();
        chk("t4_rsp_valid", 32'(s_rsp_valid), 32'd1);
        chk("t4_rsp_data",  32'(s_rsp_data),  32'h5A);
        clr_start = 1'b0;
        set_req(1, 1, 0, 9, 0);
        busy_cnt = 0;
        rdy_cnt  = 0;
        for (int k = 0; k < NREG; k++) begin
            if (k == 3) clr_start = 1'b1;
            if (k == 4) clr_start = 1'b0;
            step();
            if (s_busy) busy_cnt++;
            if (s_ready != 2'b00) rdy_cnt++;
        end
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("t4_ready_in_clr", 32'(rdy_cnt), 32'd0);
        step();
        chk("t4_post_grant", 32'(s_ready), 32'd2);
        idle();
        step();
        chk("t4_post_rspv", 32'(s_rsp_valid), 32'd2);
        chk("t4_post_data", 32'(s_rsp_data), 32'h00);

        // Move the read pointer to requester 1, then reset during CLEAR
        set_req(0, 1, 0, 4, 0);
        set_req(1, 1, 0, 5, 0);
        step();
        chk("t5_pre_grant", 32'(s_ready), 32'd1);
        idle();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        set_req(0, 1, 0, 4, 0);
        set_req(1, 1, 0, 5, 0);
        step();
        chk("t5_first_grant", 32'(s_ready), 32'd1);
        idle();
        step();

        // Randomized traffic; a requester keeps its request until accepted
        s_ready = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || s_ready[i]) begin
                    set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                            int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 255)));
                end
            end
            clr_start = ($urandom_range(0, 59) == 0);
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
